// File: rtl/matmul_acc_if.sv
`default_nettype none
// ============================================================================
// fixedp : common clock/reset bundle shared by the fixed-point datapath stages
// Rev 1.0
// ============================================================================
interface fixedp;
  logic clk;
  logic reset_l;
  modport sink (input clk, input reset_l);
endinterface
`default_nettype wire

// File: rtl/matmul_acc.sv
`default_nettype none
// ============================================================================
// matmul_acc : tile accumulator with clip, sticky errors and 2-entry out FIFO
// Rev 1.0
// ============================================================================
module matmul_acc #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int GUARD = 4
) (
  fixedp.sink                 g,
  input  logic                i_valid,
  input  logic                i_first,
  input  logic                i_last,
  input  logic [N*WIDTH-1:0]  i_data,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [N*WIDTH-1:0]  o_data,
  output logic [N-1:0]        o_sat,
  output logic                err_ovf,
  output logic                err_proto,
  input  logic                err_clr
);
  localparam int AWIDTH = WIDTH + GUARD;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [N-1:0][AWIDTH-1:0]     acc_q, acc_d;
  logic [N-1:0]                 asat_q, asat_d;
  logic [N-1:0][AWIDTH-1:0]     w_sext, w_sum_sat;
  logic [N-1:0]                 w_add_ovf, w_clip_sat;
  logic [N-1:0][WIDTH-1:0]      w_clip;

  logic [N*WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [N-1:0]       head_sat_q, head_sat_d, tail_sat_q, tail_sat_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               err_ovf_q, err_ovf_d, err_proto_q, err_proto_d;
  logic               w_load, w_add, w_proto, w_push, w_pop, w_ovf;

  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      logic [AWIDTH:0] sum;
      assign w_sext[k]     = {{GUARD{i_data[k*WIDTH+WIDTH-1]}}, i_data[k*WIDTH +: WIDTH]};
      assign sum           = {acc_q[k][AWIDTH-1], acc_q[k]} + {w_sext[k][AWIDTH-1], w_sext[k]};
      assign w_add_ovf[k]  = sum[AWIDTH] ^ sum[AWIDTH-1];
      assign w_sum_sat[k]  = w_add_ovf[k] ? {sum[AWIDTH], {(AWIDTH-1){~sum[AWIDTH]}}}
                                          : sum[AWIDTH-1:0];
      // Value fits WIDTH only when all guard bits match the WIDTH sign bit
      assign w_clip_sat[k] = acc_d[k][AWIDTH-1:WIDTH-1] != {(GUARD+1){acc_d[k][AWIDTH-1]}};
      assign w_clip[k]     = w_clip_sat[k] ? {acc_d[k][AWIDTH-1], {(WIDTH-1){~acc_d[k][AWIDTH-1]}}}
                                           : acc_d[k][WIDTH-1:0];
    end
  endgenerate

  assign w_load  = i_valid & i_first;
  assign w_add   = i_valid & ~i_first & (state_q == S_ACCUM);
  assign w_proto = i_valid & (i_first ? (state_q == S_ACCUM) : (state_q == S_IDLE));
  assign w_push  = i_valid & i_last & (w_load | w_add);
  assign w_pop   = (cnt_q != 2'd0) & o_ready;

  always_comb begin
    acc_d   = acc_q;
    asat_d  = asat_q;
    state_d = state_q;
    if (w_load) begin
      acc_d   = w_sext;
      asat_d  = '0;
      state_d = i_last ? S_IDLE : S_ACCUM;
    end else if (w_add) begin
      acc_d  = w_sum_sat;
      asat_d = asat_q | w_add_ovf;
      if (i_last) state_d = S_IDLE;
    end
  end

  // Pop is applied first so a full FIFO can accept a push in the same cycle
  always_comb begin
    head_data_d = head_data_q;
    head_sat_d  = head_sat_q;
    tail_data_d = tail_data_q;
    tail_sat_d  = tail_sat_q;
    cnt_d       = cnt_q;
    w_ovf       = 1'b0;
    if (w_pop) begin
      head_data_d = tail_data_q;
      head_sat_d  = tail_sat_q;
      cnt_d       = cnt_q - 2'd1;
    end
    if (w_push) begin
      if (cnt_d == 2'd0) begin
        head_data_d = w_clip;
        head_sat_d  = asat_d | w_clip_sat;
        cnt_d       = 2'd1;
      end else if (cnt_d == 2'd1) begin
        tail_data_d = w_clip;
        tail_sat_d  = asat_d | w_clip_sat;
        cnt_d       = 2'd2;
      end else begin
        w_ovf = 1'b1;
      end
    end
    err_ovf_d   = err_clr ? 1'b0 : (err_ovf_q | w_ovf);
    err_proto_d = err_clr ? 1'b0 : (err_proto_q | w_proto);
  end

  always_ff @(posedge g.clk) begin
    if (!g.reset_l) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      asat_q      <= '0;
      head_data_q <= '0;
      head_sat_q  <= '0;
      tail_data_q <= '0;
      tail_sat_q  <= '0;
      cnt_q       <= 2'd0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      asat_q      <= asat_d;
      head_data_q <= head_data_d;
      head_sat_q  <= head_sat_d;
      tail_data_q <= tail_data_d;
      tail_sat_q  <= tail_sat_d;
      cnt_q       <= cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign o_valid   = cnt_q != 2'd0;
  assign o_data    = head_data_q;
  assign o_sat     = head_sat_q;
  assign err_ovf   = err_ovf_q;
  assign err_proto = err_proto_q;
endmodule
`default_nettype wire
